uart_csr_bank: RTL and testbench
================================

Name: uart_csr_bank

Overview:
- Parametrised UART CSR bank; next generation of the single control register.
- Holds the frame/baud configuration register, a TX data queue of TXQ_DEPTH entries (replaces the single tnsm/tnsm_data slot), a status register with sticky write-1-to-clear flags, and an interrupt-enable register with a registered irq output.
- Sits between the bus slave and the UART TX/RX datapath.

Parameters:
- REG_W, 32: CSR data width; must be ≥ max(6+BAUD_W, DATA_W, 8+CNT_W).
- DATA_W, 8: TX character width.
- TXQ_DEPTH, 4: TX queue entries; power of 2, ≥ 2.
- BAUD_W, 4: baud_rate field width.
- BAUD_RST, 7: baud_rate reset value.
- CNT_W (derived), $clog2(TXQ_DEPTH)+1: queue occupancy width.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- we  in  1  write strobe
- addr  in  2  register select: 0 CTRL, 1 TXDATA, 2 STATUS, 3 IRQ_EN
- wmask  in  REG_W  per-bit write mask
- wdata  in  REG_W  write data
- rdata  out  REG_W  combinational read of addr; TXDATA reads 0
- active  out  1  CTRL[0]
- frame_type  out  2  CTRL[2:1]
- parity_type  out  2  CTRL[4:3]
- stop_type  out  1  CTRL[5]
- baud_rate  out  BAUD_W  CTRL[6 +: BAUD_W]
- tx_valid  out  1  queue head valid
- tx_data  out  DATA_W  queue head
- tx_ready  in  1  TX engine accepts head (pop when tx_valid & tx_ready)
- rx_err  in  1  single-cycle RX error pulse
- irq  out  1  registered interrupt

Behaviour:
- Reset: CTRL active=1, frame_type=2'b11, parity_type=0, stop_type=0, baud_rate=BAUD_RST, other bits 0. Queue empty with pointers 0, STATUS sticky flags 0, IRQ_EN 0, irq 0. Resulting outputs: tx_valid=0, tx_data=0.
- CTRL write: each bit with wmask=1 takes wdata; other bits hold. Unimplemented bits read 0.
- TXDATA write: push of wdata[DATA_W-1:0] & wmask[DATA_W-1:0] regardless of mask. Visible at tx_valid the next cycle.
- tx_valid = (count != 0) & active. tx_data = mem[rd_ptr], or 0 when empty. Pop only when tx_valid & tx_ready.
- Full, push, no pop: data dropped; ovf set.
- Full, push, and pop in the same cycle: both occur; count unchanged; no ovf.
- Empty, push, and tx_ready: push only; no pop.
- Pointers wrap modulo TXQ_DEPTH. Count saturates naturally in 0..TXQ_DEPTH.
- CTRL write that clears active (1→0): queue flushes at that edge (count=0, pointers 0). While active=0, pushes are still accepted and held, and tx_valid=0.
- STATUS layout:
  - [0] empty (RO)
  - [1] full (RO)
  - [2] ovf (sticky, W1C)
  - [3] rx_err (sticky, W1C)
  - [8 +: CNT_W] count (RO)
- W1C applies on bits where wdata=1 and wmask=1. If a set event and a clear land in the same cycle, set wins.
- IRQ_EN layout: [0] empty_en, [1] ovf_en, [2] rx_err_en. Bits are masked-writable; other bits read 0.
- irq <= (empty & en0) | (ovf & en1) | (rx_err_flag & en2). Registered: asserts one cycle after the condition and drops one cycle after it clears.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any in-flight handshake is abandoned.

Decomposition:
- Package uart_csr_pkg:
  - address enum (CSR_CTRL, CSR_TXDATA, CSR_STATUS, CSR_IRQEN)
  - CTRL/STATUS/IRQ_EN bit-position localparams
  - CTRL reset constants
- Sub-module uart_txq: synchronous FIFO (DATA_W, TXQ_DEPTH) with push/pop/flush, full/empty/count. The CSR decode, status and irq logic stay in the top.

Test Plan:
- Reset, then read addr 0 → rdata = 0x1C7 (active=1, frame=3, baud=7). Read addr 2 → 0x001 (empty=1, count=0). tx_valid=0, irq=0.
- Write CTRL wdata=0x000, wmask=0x006 → frame_type=0; active and baud unchanged; rdata=0x1C1.
- tx_ready=0; push 0x11, 0x22, 0x33, 0x44 → STATUS full=1, count=4. Push 0x55 → ovf=1, count stays 4. Pop all with tx_ready=1 → tx_data sequence 0x11, 0x22, 0x33, 0x44, then tx_valid=0.
- When full, push 0x66 in the same cycle as a pop → count stays 4, no ovf, and 0x66 emerges last.
- Set IRQ_EN=0x4 and pulse rx_err → irq=1 one cycle later. Write STATUS wdata=0x8, wmask=0x8 → flag clears and irq=0 the following cycle. Repeat with rx_err pulsed in the same cycle as the clear → flag stays 1.
- Push 2 entries, then write CTRL active=0 → count=0, tx_valid=0. Drop arst_n mid-pop → all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_csr_pkg.sv
// Register map constants shared by the UART CSR bank and its bench-facing decode.
// Pure declarations: no logic, no latency, no flow control.
package uart_csr_pkg;

  typedef enum logic [1:0] {
    CSR_CTRL   = 2'd0,
    CSR_TXDATA = 2'd1,
    CSR_STATUS = 2'd2,
    CSR_IRQEN  = 2'd3
  } csr_addr_e;

  localparam int CTRL_ACTIVE     = 0;
  localparam int CTRL_FRAME_LSB  = 1;
  localparam int CTRL_PARITY_LSB = 3;
  localparam int CTRL_STOP       = 5;
  localparam int CTRL_BAUD_LSB   = 6;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_RXERR   = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int IE_EMPTY = 0;
  localparam int IE_OVF   = 1;
  localparam int IE_RXERR = 2;
  localparam int IE_W     = 3;

  localparam logic       ACTIVE_RST = 1'b1;
  localparam logic [1:0] FRAME_RST  = 2'b11;
  localparam logic [1:0] PARITY_RST = 2'b00;
  localparam logic       STOP_RST   = 1'b0;

endpackage

// File: rtl/uart_txq.sv
// TX character FIFO with flush; push visible at head one cycle later, head is combinational.
// A push when full is accepted only if a pop frees a slot in the same cycle, otherwise dropped.
module uart_txq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_dat,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // Pointer widths equal log2(DEPTH), so increments wrap modulo DEPTH.
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_q] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem[rd_q];

endmodule

// File: rtl/uart_csr_bank.sv
// UART CSR bank: CTRL, TX queue, sticky STATUS, IRQ_EN; reads combinational, writes and irq take one cycle.
// TX head is offered with tx_valid/tx_ready; a push into a full queue with no pop is dropped and flags ovf.
module uart_csr_bank
  import uart_csr_pkg::*;
#(
  parameter int REG_W     = 32,
  parameter int DATA_W    = 8,
  parameter int TXQ_DEPTH = 4,
  parameter int BAUD_W    = 4,
  parameter int BAUD_RST  = 7,
  localparam int CNT_W    = $clog2(TXQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [REG_W-1:0]  wmask,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata,
  output logic              active,
  output logic [1:0]        frame_type,
  output logic [1:0]        parity_type,
  output logic              stop_type,
  output logic [BAUD_W-1:0] baud_rate,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_err,
  output logic              irq
);

  localparam int CTRL_W = 6 + BAUD_W;
  localparam logic [CTRL_W-1:0] CTRL_RST =
    {BAUD_W'(BAUD_RST), STOP_RST, PARITY_RST, FRAME_RST, ACTIVE_RST};

  csr_addr_e         sel;
  logic              wr_ctrl, wr_txd, wr_stat, wr_ien;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [IE_W-1:0]   ien_q, ien_d;
  logic              ovf_q, ovf_d, rxf_q, rxf_d, irq_q, irq_d;
  logic [REG_W-1:0]  w1c, status_rd;
  logic              flush, pop, ovf_set;
  logic              q_empty, q_full;
  logic [CNT_W-1:0]  q_count;
  logic [DATA_W-1:0] q_head;
  logic              unused_wbits;

  assign sel     = csr_addr_e'(addr);
  assign wr_ctrl = we & (sel == CSR_CTRL);
  assign wr_txd  = we & (sel == CSR_TXDATA);
  assign wr_stat = we & (sel == CSR_STATUS);
  assign wr_ien  = we & (sel == CSR_IRQEN);
  assign w1c     = wdata & wmask & {REG_W{wr_stat}};
  assign unused_wbits = ^{wdata[REG_W-1:CTRL_W], wmask[REG_W-1:CTRL_W]};

  assign ctrl_d = wr_ctrl ? ((ctrl_q & ~wmask[CTRL_W-1:0]) | (wdata[CTRL_W-1:0] & wmask[CTRL_W-1:0]))
                          : ctrl_q;
  assign ien_d  = wr_ien ? ((ien_q & ~wmask[IE_W-1:0]) | (wdata[IE_W-1:0] & wmask[IE_W-1:0]))
                         : ien_q;
  // Falling edge of active empties the queue on the same clock that commits the write.
  assign flush  = ctrl_q[CTRL_ACTIVE] & ~ctrl_d[CTRL_ACTIVE];

  assign tx_valid = ~q_empty & ctrl_q[CTRL_ACTIVE];
  assign tx_data  = q_head;
  assign pop      = tx_valid & tx_ready;
  assign ovf_set  = wr_txd & q_full & ~pop;

  uart_txq #(
    .DATA_W (DATA_W),
    .DEPTH  (TXQ_DEPTH)
  ) u_txq (
    .clk      (clk),
    .arst_n   (arst_n),
    .push     (wr_txd),
    .push_dat (wdata[DATA_W-1:0] & wmask[DATA_W-1:0]),
    .pop      (pop),
    .flush    (flush),
    .head_dat (q_head),
    .empty    (q_empty),
    .full     (q_full),
    .count    (q_count)
  );

  // Set events override a simultaneous write-1-to-clear.
  assign ovf_d = ovf_set | (ovf_q & ~w1c[ST_OVF]);
  assign rxf_d = rx_err  | (rxf_q & ~w1c[ST_RXERR]);
  assign irq_d = (q_empty & ien_q[IE_EMPTY]) | (ovf_q & ien_q[IE_OVF]) | (rxf_q & ien_q[IE_RXERR]);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_q <= CTRL_RST;
      ien_q  <= '0;
      ovf_q  <= 1'b0;
      rxf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      ien_q  <= ien_d;
      ovf_q  <= ovf_d;
      rxf_q  <= rxf_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    status_rd = '0;
    status_rd[ST_EMPTY]              = q_empty;
    status_rd[ST_FULL]               = q_full;
    status_rd[ST_OVF]                = ovf_q;
    status_rd[ST_RXERR]              = rxf_q;
    status_rd[ST_CNT_LSB +: CNT_W]   = q_count;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      CSR_CTRL:   rdata = REG_W'(ctrl_q);
      CSR_STATUS: rdata = status_rd;
      CSR_IRQEN:  rdata = REG_W'(ien_q);
      default:    rdata = '0;
    endcase
  end

  assign active      = ctrl_q[CTRL_ACTIVE];
  assign frame_type  = ctrl_q[CTRL_FRAME_LSB +: 2];
  assign parity_type = ctrl_q[CTRL_PARITY_LSB +: 2];
  assign stop_type   = ctrl_q[CTRL_STOP];
  assign baud_rate   = ctrl_q[CTRL_BAUD_LSB +: BAUD_W];
  assign irq         = irq_q;

endmodule

// File: tb/tb_uart_csr_bank.sv
// Bench for uart_csr_bank: directed register-map walk, then random traffic against a queue-based model.
module tb_uart_csr_bank;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wmask, wdata, rdata;
  logic        active, stop_type, tx_valid, tx_ready, rx_err, irq;
  logic [1:0]  frame_type, parity_type;
  logic [3:0]  baud_rate;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_csr_bank #(
    .REG_W(32), .DATA_W(8), .TXQ_DEPTH(4), .BAUD_W(4), .BAUD_RST(7)
  ) dut (
    .clk(clk), .arst_n(arst_n), .we(we), .addr(addr), .wmask(wmask), .wdata(wdata),
    .rdata(rdata), .active(active), .frame_type(frame_type), .parity_type(parity_type),
    .stop_type(stop_type), .baud_rate(baud_rate), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_err(rx_err), .irq(irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register images plus a plain queue for the TX FIFO.
  logic [9:0] m_ctrl;
  logic [7:0] m_q[$];
  logic [2:0] m_ien;
  logic       m_ovf, m_rxf, m_irq;

  task automatic m_reset();
    m_ctrl = 10'h1C7;
    m_q.delete();
    m_ien = '0;
    m_ovf = 1'b0;
    m_rxf = 1'b0;
    m_irq = 1'b0;
  endtask

  function automatic logic m_txv();
    return (m_q.size() != 0) && m_ctrl[0];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_q.size()) << 8;
    s[0] = (m_q.size() == 0);
    s[1] = (m_q.size() == 4);
    s[2] = m_ovf;
    s[3] = m_rxf;
    return s;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_ctrl);
      2'd2:    return m_status();
      2'd3:    return 32'(m_ien);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("rdata", rdata, m_rdata(addr));
    chk("tx_valid", 32'(tx_valid), 32'(m_txv()));
    chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("ctrl_fields", {19'h0, baud_rate, stop_type, parity_type, frame_type, active}, 32'(m_ctrl));
  endtask

  // One clock: check outputs mid-cycle, then advance the model with the same inputs.
  task automatic step();
    logic [9:0] nctrl;
    logic [2:0] nien;
    logic       pop, push, full, empty, flush, ovf_set, clr_ovf, clr_rxf, nirq;
    #1;
    check_outputs();
    full    = (m_q.size() == 4);
    empty   = (m_q.size() == 0);
    pop     = m_txv() && tx_ready;
    push    = we && (addr == 2'd1);
    nctrl   = (we && addr == 2'd0) ? ((m_ctrl & ~wmask[9:0]) | (wdata[9:0] & wmask[9:0])) : m_ctrl;
    nien    = (we && addr == 2'd3) ? ((m_ien & ~wmask[2:0]) | (wdata[2:0] & wmask[2:0])) : m_ien;
    flush   = m_ctrl[0] && !nctrl[0];
    ovf_set = push && full && !pop;
    clr_ovf = we && (addr == 2'd2) && wdata[2] && wmask[2];
    clr_rxf = we && (addr == 2'd2) && wdata[3] && wmask[3];
    nirq    = (empty && m_ien[0]) || (m_ovf && m_ien[1]) || (m_rxf && m_ien[2]);
    @(posedge clk);
    if (flush) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push && (!full || pop)) m_q.push_back(wdata[7:0] & wmask[7:0]);
    end
    m_ovf  = ovf_set || (m_ovf && !clr_ovf);
    m_rxf  = rx_err  || (m_rxf && !clr_rxf);
    m_ctrl = nctrl;
    m_ien  = nien;
    m_irq  = nirq;
    #1;
  endtask

  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] m, input logic rdy, input logic re);
    we = w; addr = a; wdata = d; wmask = m; tx_ready = rdy; rx_err = re;
    step();
  endtask

  task automatic peek(input logic [1:0] a);
    we = 1'b0; addr = a; tx_ready = 1'b0; rx_err = 1'b0;
    #1;
  endtask

  logic [7:0] exp_seq [4];

  initial begin
    arst_n = 1'b0; we = 0; addr = 0; wdata = 0; wmask = 0; tx_ready = 0; rx_err = 0;
    m_reset();
    #12 arst_n = 1'b1;

    peek(2'd0); chk("rst_ctrl", rdata, 32'h1C7);
    peek(2'd2); chk("rst_status", rdata, 32'h001);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    cyc(1, 2'd0, 32'h000, 32'h006, 0, 0);
    peek(2'd0); chk("ctrl_masked", rdata, 32'h1C1);

    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cyc(1, 2'd1, 32'(exp_seq[i]), 32'hFFFF_FFFF, 0, 0);
    peek(2'd2); chk("full_status", rdata, 32'h402);
    cyc(1, 2'd1, 32'h55, 32'hFFFF_FFFF, 0, 0);
    peek(2'd2); chk("ovf_status", rdata, 32'h406);
    for (int i = 0; i < 4; i++) begin
      peek(2'd0); chk("pop_seq", 32'(tx_data), 32'(exp_seq[i]));
      cyc(0, 2'd0, 0, 0, 1, 0);
    end
    chk("drained_valid", 32'(tx_valid), 32'h0);

    cyc(1, 2'd2, 32'h4, 32'h4, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 2'd1, 32'(i), 32'hFF, 0, 0);
    cyc(1, 2'd1, 32'h66, 32'hFF, 1, 0);
    peek(2'd2); chk("push_pop_full", rdata, 32'h402);
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h66};
    for (int i = 0; i < 4; i++) begin
      peek(2'd0); chk("pop_seq2", 32'(tx_data), 32'(exp_seq[i]));
      cyc(0, 2'd0, 0, 0, 1, 0);
    end

    cyc(1, 2'd3, 32'h4, 32'h7, 0, 0);
    cyc(0, 2'd0, 0, 0, 0, 1);
    cyc(0, 2'd0, 0, 0, 0, 0);
    chk("irq_rxerr", 32'(irq), 32'h1);
    cyc(1, 2'd2, 32'h8, 32'h8, 0, 0);
    cyc(0, 2'd0, 0, 0, 0, 0);
    chk("irq_cleared", 32'(irq), 32'h0);
    cyc(0, 2'd0, 0, 0, 0, 1);
    cyc(1, 2'd2, 32'h8, 32'h8, 0, 1);
    peek(2'd2); chk("set_beats_clear", 32'(rdata[3]), 32'h1);

    cyc(1, 2'd1, 32'hA1, 32'hFF, 0, 0);
    cyc(1, 2'd1, 32'hA2, 32'hFF, 0, 0);
    cyc(1, 2'd0, 32'h0, 32'h1, 0, 0);
    peek(2'd2); chk("flush_status", rdata, 32'h009);
    chk("flush_valid", 32'(tx_valid), 32'h0);
    cyc(1, 2'd1, 32'hB1, 32'hFF, 0, 0);
    chk("inactive_hold_valid", 32'(tx_valid), 32'h0);
    cyc(1, 2'd0, 32'h1, 32'h1, 0, 0);
    cyc(1, 2'd1, 32'hB2, 32'hFF, 0, 0);
    cyc(0, 2'd0, 0, 0, 1, 0);

    tx_ready = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_tx_data", 32'(tx_data), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    addr = 2'd0; #1 chk("arst_ctrl", rdata, 32'h1C7);
    #2 arst_n = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] d, m;
      logic [1:0]  a;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      m = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
      if (a == 2'd0 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
      cyc(1'($urandom_range(0, 1)), a, d, m,
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
